src_frame_ctrl: RTL and testbench

SRC_FRAME_CTRL -- requirements
Module: src_frame_ctrl

---
 rtl/src_frame_ctrl.sv | 128 ++++++++++++
 tb/tb_src_frame_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/src_frame_ctrl.sv
// Frame controller: pulls preamble and payload bytes from an external source
// generator and streams them out through a 4-entry FIFO under a credit limit.
module src_frame_ctrl #(
  parameter int unsigned PRE_LEN = 4,
  parameter int unsigned PAY_LEN = 48,
  parameter int unsigned GAP_LEN = 2
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        start,
  input  logic        cont,
  output logic        src_ready,
  output logic        src_mode,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, PRE, PAY, GAP} state_e;

  localparam logic [15:0] PRE_END = 16'(PRE_LEN - 1);
  localparam logic [15:0] PAY_END = 16'(PAY_LEN - 1);
  localparam logic [15:0] GAP_END = 16'(GAP_LEN - 1);
  localparam state_e      FIRST   = (PRE_LEN == 0) ? PAY : PRE;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  fifo_cnt_q;
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [8:0]  mem_q [4];
  logic        inflight_q, infl_last_q;
  logic [15:0] frame_cnt_q;
  logic        err_q;

  logic       credit_ok, pull, pull_last, pop;
  logic [8:0] head;

  // Credit counts both stored bytes and the byte still on its way from the source.
  assign credit_ok = ({1'b0, fifo_cnt_q} + {3'b000, inflight_q}) < 4'd4;
  assign pull      = (state_q == PRE || state_q == PAY) && credit_ok;
  assign pull_last = pull && (state_q == PAY) && (cnt_q == PAY_END);
  assign head      = mem_q[rd_ptr_q];
  assign pop       = m_valid && m_ready;

  assign src_ready = pull;
  assign src_mode  = pull && (state_q == PRE);
  assign m_valid   = (fifo_cnt_q != 3'd0);
  assign m_data    = m_valid ? head[7:0] : 8'h00;
  assign m_last    = m_valid && head[8];
  assign busy      = (state_q != IDLE) || m_valid;
  assign frame_cnt = frame_cnt_q;
  assign err       = err_q;

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= FIRST;
          cnt_q   <= '0;
        end
        PRE: if (pull) begin
          if (cnt_q == PRE_END) begin
            state_q <= PAY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        PAY: if (pull) begin
          if (pull_last) begin
            cnt_q <= '0;
            // With no gap the cont decision is taken on the final pull itself.
            if (GAP_LEN != 0) state_q <= GAP;
            else              state_q <= cont ? FIRST : IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_END) begin
            state_q <= cont ? FIRST : IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      inflight_q  <= pull;
      infl_last_q <= pull_last;
      if (inflight_q) begin
        mem_q[wr_ptr_q] <= {infl_last_q, src_data};
        wr_ptr_q        <= wr_ptr_q + 2'd1;
        if (!src_valid) err_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
        if (head[8]) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      case ({inflight_q, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end
endmodule

// File: tb/tb_src_frame_ctrl.sv
// Bench for src_frame_ctrl: byte-stream reference model plus directed frame
// scenarios on a 4/8/2 instance and a wrap/no-preamble run on a 0/1/0 instance.
module tb_src_frame_ctrl;
  localparam int PRE = 4, PAY = 8, GAP = 2, FLEN = PRE + PAY;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        reset, start, cont, m_ready, src_valid, src_ready, src_mode;
  logic        m_valid, m_last, busy, err;
  logic [7:0]  src_data, m_data;
  logic [15:0] frame_cnt;

  logic        e_reset, e_start, e_cont, e_m_ready, e_src_valid, e_src_ready, e_src_mode;
  logic        e_m_valid, e_m_last, e_busy, e_err;
  logic [7:0]  e_src_data, e_m_data;
  logic [15:0] e_frame_cnt;

  src_frame_ctrl #(.PRE_LEN(PRE), .PAY_LEN(PAY), .GAP_LEN(GAP)) u0 (
    .aclk(aclk), .reset(reset), .start(start), .cont(cont),
    .src_ready(src_ready), .src_mode(src_mode), .src_data(src_data), .src_valid(src_valid),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .frame_cnt(frame_cnt), .err(err));

  src_frame_ctrl #(.PRE_LEN(0), .PAY_LEN(1), .GAP_LEN(0)) u1 (
    .aclk(aclk), .reset(e_reset), .start(e_start), .cont(e_cont),
    .src_ready(e_src_ready), .src_mode(e_src_mode), .src_data(e_src_data), .src_valid(e_src_valid),
    .m_data(e_m_data), .m_valid(e_m_valid), .m_last(e_m_last), .m_ready(e_m_ready),
    .busy(e_busy), .frame_cnt(e_frame_cnt), .err(e_err));

  int   checks = 0, errors = 0;
  logic drop_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk); #1;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Source generators: answer a pull one cycle later, reset with the DUT.
  initial begin
    logic p, md, r;
    logic [7:0] l;
    src_data = 8'h00; src_valid = 1'b0; l = 8'h01;
    forever begin
      @(negedge aclk); p = src_ready; md = src_mode; r = reset;
      step();
      if (r) begin
        l = 8'h01; src_valid = 1'b0; src_data = 8'h00;
      end else if (p) begin
        src_data = md ? 8'hAA : l;
        if (!md) l = lfsr_next(l);
        src_valid = !(drop_en && $urandom_range(0, 15) == 0);
      end else src_valid = 1'b0;
    end
  end

  initial begin
    logic p, md, r;
    logic [7:0] l;
    e_src_data = 8'h00; e_src_valid = 1'b0; l = 8'h01;
    forever begin
      @(negedge aclk); p = e_src_ready; md = e_src_mode; r = e_reset;
      step();
      if (r) begin
        l = 8'h01; e_src_valid = 1'b0;
      end else if (p) begin
        e_src_data = md ? 8'hAA : l;
        if (!md) l = lfsr_next(l);
        e_src_valid = 1'b1;
      end else e_src_valid = 1'b0;
    end
  end

  // Reference model: frames are FLEN pulls, preamble first, last byte tagged;
  // bytes leave in pull order; at most 4 bytes outstanding.
  typedef struct packed { logic last; logic [7:0] data; } ent_t;
  ent_t        mq[$];
  int          k = 0, pend = 0, cyc = 0, last_end = -1000;
  logic        inf = 1'b0, inf_last = 1'b0, merr = 1'b0;
  logic [15:0] fc = '0;

  initial begin
    forever begin
      @(negedge aclk);
      chk("m_valid", m_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("m_data", m_data, mq[0].data);
        chk("m_last", m_last, mq[0].last);
        chk("busy", busy, 1);
      end
      chk("frame_cnt", frame_cnt, fc);
      chk("err", err, merr);
      if (!src_ready) chk("src_mode_idle", src_mode, 0);
      else begin
        chk("credit", pend < 4, 1);
        chk("src_mode", src_mode, k < PRE);
        chk("gap_len", (cyc - last_end) > GAP, 1);
      end
      if (reset) begin
        mq.delete(); k = 0; pend = 0; inf = 1'b0; merr = 1'b0; fc = '0; last_end = -1000;
      end else begin
        if (mq.size() != 0 && m_ready) begin
          if (mq[0].last) fc++;
          void'(mq.pop_front());
          pend--;
        end
        if (inf) begin
          mq.push_back('{inf_last, src_data});
          if (!src_valid) merr = 1'b1;
        end
        inf = src_ready;
        if (src_ready) begin
          inf_last = (k == FLEN - 1);
          if (k == FLEN - 1) last_end = cyc;
          pend++;
          k = (k + 1) % FLEN;
        end
      end
      cyc++;
    end
  end

  // No-preamble, one-byte-frame instance: runs back to back until frame_cnt wraps.
  logic [15:0] efc = '0, e_prev = '0;
  logic        e_seen = 1'b0, e_wrapped = 1'b0;
  initial begin
    e_reset = 1'b1; e_start = 1'b0; e_cont = 1'b1; e_m_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 e_reset = 1'b0; e_start = 1'b1;
    step(); e_start = 1'b0;
  end
  initial begin
    forever begin
      @(negedge aclk);
      if (!e_reset) begin
        chk("wrap_cnt", e_frame_cnt, efc);
        if (e_src_ready) chk("pre0_mode", e_src_mode, 0);
        if (e_prev == 16'hFFFF && e_frame_cnt == 16'h0000) e_wrapped = 1'b1;
        e_prev = e_frame_cnt;
        if (e_m_valid) begin
          chk("pre0_last", e_m_last, 1);
          if (!e_seen) begin
            chk("pre0_first", e_m_data, 8'h01);
            e_seen = 1'b1;
          end
          if (e_m_ready) efc++;
        end
      end
    end
  end

  logic [20:0] rdy, vld, lst;
  logic [7:0]  dat [21];
  logic [7:0]  exp_dat [7] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h01, 8'h02, 8'h04};
  int          npull, npop, nlast;

  initial begin
    reset = 1'b1; start = 1'b0; cont = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 reset = 1'b0;
    @(negedge aclk);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err", err, 0);

    // Nominal frame; the start pulse in cycle 8 lands in PAY and must be ignored.
    step(); start = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge aclk);
      rdy[i] = src_ready; vld[i] = m_valid; lst[i] = m_last; dat[i] = m_data;
      step(); start = (i == 7);
    end
    for (int i = 0; i < 21; i++) begin
      chk($sformatf("nom_src_ready[%0d]", i), rdy[i], i >= 1 && i <= 12);
      chk($sformatf("nom_m_valid[%0d]", i), vld[i], i >= 3 && i <= 14);
      chk($sformatf("nom_m_last[%0d]", i), lst[i], i == 14);
    end
    for (int i = 0; i < 7; i++) chk($sformatf("nom_m_data[%0d]", i + 3), dat[i + 3], exp_dat[i]);
    @(negedge aclk);
    chk("nom_frame_cnt", frame_cnt, 1);

    // Backpressure: credit stops pulls at 4, then everything drains in order.
    step(); m_ready = 1'b0; start = 1'b1;
    npull = 0; npop = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk); if (src_ready) npull++;
      step(); start = 1'b0;
    end
    @(negedge aclk);
    chk("bp_pulls", npull, 4);
    chk("bp_stalled", src_ready, 0);
    chk("bp_fifo_full_valid", m_valid, 1);
    step(); m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk); if (m_valid && m_ready) npop++;
      step();
    end
    chk("bp_delivered", npop, 12);
    chk("bp_frame_cnt", frame_cnt, 2);

    // Continuous: three frames back to back with a 2-cycle gap each.
    step(); start = 1'b1; cont = 1'b1;
    nlast = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      chk($sformatf("cont_src_ready[%0d]", i), src_ready,
          (i >= 1 && i <= 12) || (i >= 15 && i <= 26) || (i >= 29 && i <= 40));
      if (m_valid && m_ready && m_last) nlast++;
      step(); start = 1'b0;
      if (i == 30) cont = 1'b0;
    end
    chk("cont_m_last_count", nlast, 3);
    chk("cont_frame_cnt", frame_cnt, 5);

    // Reset asserted during cycle 7 of a frame.
    step(); start = 1'b1;
    for (int i = 0; i < 7; i++) begin step(); start = 1'b0; end
    reset = 1'b1;
    step(); reset = 1'b0;
    @(negedge aclk);
    chk("mid_rst_src_ready", src_ready, 0);
    chk("mid_rst_src_mode", src_mode, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_m_last", m_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    repeat (3) step();
    @(negedge aclk);
    chk("mid_rst_idle", src_ready, 0);

    // Randomized traffic, occasional resets, later with dropped src_valid.
    for (int i = 0; i < 3000; i++) begin
      step();
      m_ready = ($urandom_range(0, 9) < 7);
      start   = ($urandom_range(0, 7) == 0);
      cont    = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 499) == 0);
      drop_en = (i >= 2000);
    end
    step(); m_ready = 1'b1; start = 1'b0; cont = 1'b0; reset = 1'b0; drop_en = 1'b0;
    begin
      int n;
      n = 0;
      while ((busy || src_ready) && n < 200) begin @(negedge aclk); n++; end
      chk("rand_drain", busy, 0);
    end

    begin
      int n;
      n = 0;
      while (!e_wrapped && n < 70000) begin @(negedge aclk); n++; end
      chk("pre0_wrapped", e_wrapped, 1);
      chk("pre0_seen", e_seen, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
